// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: reset vector and the PC generator state encoding.
// Kept as plain localparams so legacy blocks comparing raw state codes still work.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h1fc0_0000;

  typedef logic [1:0] pc_state_t;

  localparam pc_state_t S_BOOT = 2'd0;
  localparam pc_state_t S_RUN  = 2'd1;
  localparam pc_state_t S_PEND = 2'd2;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for redirects that arrive while the fetch stage is stalled.
// An exception always takes the slot; a branch never displaces a buffered exception.
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              is_branch,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              is_exception,
  input  logic [ADDR_W-1:0] exc_address,
  output logic              pend_valid,
  output logic              pend_exc,
  output logic [ADDR_W-1:0] pend_address,
  output logic              capture
);

  logic branch_ok;

  assign branch_ok = is_branch && !(pend_valid && pend_exc);
  assign capture   = !adv && (is_exception || branch_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid   <= 1'b0;
      pend_exc     <= 1'b0;
      pend_address <= '0;
    end else if (adv) begin
      // Advancing consumes the slot even if a live exception outranked it.
      pend_valid <= 1'b0;
      pend_exc   <= 1'b0;
    end else if (is_exception) begin
      pend_valid   <= 1'b1;
      pend_exc     <= 1'b1;
      pend_address <= exc_address;
    end else if (branch_ok) begin
      pend_valid   <= 1'b1;
      pend_exc     <= 1'b0;
      pend_address <= branch_address;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: sequential increment, exception/branch redirects with
// priority, a one-cycle boot state after reset and stalled-redirect buffering.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] PC_INITIAL = ADDR_W'(RESET_VECTOR),
  parameter int              INSN_BYTES = 4,
  parameter int              ALIGN_BITS = $clog2(INSN_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              is_branch,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              is_exception,
  input  logic [ADDR_W-1:0] exc_address,
  output logic [ADDR_W-1:0] pc_reg,
  output logic              pc_valid,
  output logic              pc_misaligned,
  output logic              redirect_pending
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSN_BYTES);

  pc_state_t         state;
  logic              adv;
  logic              pend_valid;
  logic              pend_exc;
  logic [ADDR_W-1:0] pend_address;
  logic              capture;
  logic [ADDR_W-1:0] next_pc;

  assign adv = enable && (state != S_BOOT);

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .adv           (adv),
    .is_branch     (is_branch),
    .branch_address(branch_address),
    .is_exception  (is_exception),
    .exc_address   (exc_address),
    .pend_valid    (pend_valid),
    .pend_exc      (pend_exc),
    .pend_address  (pend_address),
    .capture       (capture)
  );

  // NOTE: next_pc gets a default before the priority chain so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_pc = pc_reg + PC_STEP;
    if (is_exception)               next_pc = exc_address;
    else if (pend_valid && pend_exc) next_pc = pend_address;
    else if (is_branch)             next_pc = branch_address;
    else if (pend_valid)            next_pc = pend_address;
  end

  // Misalignment is registered with the PC; low bits are never masked so the
  // exception unit sees the faulting address verbatim.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg        <= PC_INITIAL;
      pc_misaligned <= |(PC_INITIAL & ALIGN_MASK);
      state         <= S_BOOT;
    end else if (adv) begin
      pc_reg        <= next_pc;
      pc_misaligned <= |(next_pc & ALIGN_MASK);
      state         <= S_RUN;
    end else if (capture) begin
      state <= S_PEND;
    end else if (state == S_BOOT) begin
      state <= S_RUN;
    end
  end

  assign pc_valid         = (state != S_BOOT);
  assign redirect_pending = (state == S_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a vector table on the default 32-bit instance plus
// hand-written sequences on it and on a 16-bit, 2-byte-instruction instance.
module tb_pc_gen;

  typedef struct {
    logic        rst_n;
    logic        enable;
    logic        is_branch;
    logic [31:0] branch_address;
    logic        is_exception;
    logic [31:0] exc_address;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_mis;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        is_branch;
  logic [31:0] branch_address;
  logic        is_exception;
  logic [31:0] exc_address;
  logic [31:0] pc_reg;
  logic        pc_valid;
  logic        pc_misaligned;
  logic        redirect_pending;

  logic        rst_n2;
  logic        enable2;
  logic        is_branch2;
  logic [15:0] branch_address2;
  logic        is_exception2;
  logic [15:0] exc_address2;
  logic [15:0] pc_reg2;
  logic        pc_valid2;
  logic        pc_misaligned2;
  logic        redirect_pending2;

  int checks = 0;
  int errors = 0;

  pc_gen u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .is_branch       (is_branch),
    .branch_address  (branch_address),
    .is_exception    (is_exception),
    .exc_address     (exc_address),
    .pc_reg          (pc_reg),
    .pc_valid        (pc_valid),
    .pc_misaligned   (pc_misaligned),
    .redirect_pending(redirect_pending)
  );

  pc_gen #(
    .ADDR_W    (16),
    .INSN_BYTES(2)
  ) u_dut16 (
    .clk             (clk),
    .rst_n           (rst_n2),
    .enable          (enable2),
    .is_branch       (is_branch2),
    .branch_address  (branch_address2),
    .is_exception    (is_exception2),
    .exc_address     (exc_address2),
    .pc_reg          (pc_reg2),
    .pc_valid        (pc_valid2),
    .pc_misaligned   (pc_misaligned2),
    .redirect_pending(redirect_pending2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic add(input logic r, input logic en, input logic br, input logic [31:0] ba,
                     input logic ex, input logic [31:0] ea, input logic [31:0] pc,
                     input logic v, input logic m, input logic p);
    vec_t t;
    t.rst_n = r; t.enable = en; t.is_branch = br; t.branch_address = ba;
    t.is_exception = ex; t.exc_address = ea;
    t.exp_pc = pc; t.exp_valid = v; t.exp_mis = m; t.exp_pend = p;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic en, input logic br, input logic [31:0] ba,
                       input logic ex, input logic [31:0] ea);
    rst_n = r; enable = en; is_branch = br; branch_address = ba;
    is_exception = ex; exc_address = ea;
  endtask

  task automatic step_check(input string tag, input logic [31:0] pc, input logic v,
                            input logic m, input logic p);
    @(posedge clk);
    #1;
    check({tag, " pc"}, pc_reg, pc);
    check({tag, " valid"}, 32'(pc_valid), 32'(v));
    check({tag, " mis"}, 32'(pc_misaligned), 32'(m));
    check({tag, " pend"}, 32'(redirect_pending), 32'(p));
  endtask

  task automatic step16(input string tag, input logic r, input logic en, input logic br,
                        input logic [15:0] ba, input logic [15:0] pc, input logic v,
                        input logic m);
    rst_n2 = r; enable2 = en; is_branch2 = br; branch_address2 = ba;
    @(posedge clk);
    #1;
    check({tag, " pc"}, 32'(pc_reg2), 32'(pc));
    check({tag, " valid"}, 32'(pc_valid2), 32'(v));
    check({tag, " mis"}, 32'(pc_misaligned2), 32'(m));
  endtask

  initial begin
    // Each row: inputs applied for one edge, then the state expected after it.
    //   rst en br  branch_addr    ex exc_addr       pc             v  m  p
    add(0, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00000, 0, 0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00000, 0, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00000, 1, 0, 0); // boot exit
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00004, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00008, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc0000c, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00010, 1, 0, 0);
    add(1, 1, 1, 32'h80000100, 0, 32'h0,        32'h80000100, 1, 0, 0); // live branch
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h80000104, 1, 0, 0);
    add(1, 0, 1, 32'h80000200, 0, 32'h0,        32'h80000104, 1, 0, 1); // stalled branch
    add(1, 0, 0, 32'h0,        0, 32'h0,        32'h80000104, 1, 0, 1);
    add(1, 0, 0, 32'h0,        0, 32'h0,        32'h80000104, 1, 0, 1);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h80000200, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h80000204, 1, 0, 0);
    add(1, 0, 1, 32'h80000300, 0, 32'h0,        32'h80000204, 1, 0, 1); // stall priority
    add(1, 0, 0, 32'h0,        1, 32'hbfc00380, 32'h80000204, 1, 0, 1);
    add(1, 0, 1, 32'h80000400, 0, 32'h0,        32'h80000204, 1, 0, 1);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00380, 1, 0, 0);
    add(1, 1, 1, 32'h80000500, 1, 32'hbfc00400, 32'hbfc00400, 1, 0, 0); // both live
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00404, 1, 0, 0);
    add(1, 1, 1, 32'hfffffffc, 0, 32'h0,        32'hfffffffc, 1, 0, 0); // wrap
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h00000000, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h00000004, 1, 0, 0);
    add(1, 1, 1, 32'h80000102, 0, 32'h0,        32'h80000102, 1, 1, 0); // misaligned
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h80000106, 1, 1, 0);
    add(1, 1, 1, 32'h80000200, 0, 32'h0,        32'h80000200, 1, 0, 0);
    add(1, 0, 1, 32'h80000600, 0, 32'h0,        32'h80000200, 1, 0, 1); // reset mid-pending
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h1fc00000, 0, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00000, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00004, 1, 0, 0);
    add(1, 0, 1, 32'h80000700, 0, 32'h0,        32'h1fc00004, 1, 0, 1); // live exc beats pend br
    add(1, 1, 0, 32'h0,        1, 32'hbfc00500, 32'hbfc00500, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00504, 1, 0, 0);
    add(1, 0, 0, 32'h0,        1, 32'hbfc00600, 32'hbfc00504, 1, 0, 1); // pend exc beats live br
    add(1, 1, 1, 32'h80000800, 0, 32'h0,        32'hbfc00600, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00604, 1, 0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00000, 0, 0, 0); // capture in boot
    add(1, 1, 1, 32'h80000900, 0, 32'h0,        32'h1fc00000, 1, 0, 1);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h80000900, 1, 0, 0);
    add(0, 1, 1, 32'h80000a00, 0, 32'h0,        32'h1fc00000, 0, 0, 0); // live req under reset
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00000, 1, 0, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,        32'h1fc00004, 1, 0, 0);

    rst_n2 = 1'b0; enable2 = 1'b0; is_branch2 = 1'b0; branch_address2 = '0;
    is_exception2 = 1'b0; exc_address2 = '0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].enable, vecs[i].is_branch, vecs[i].branch_address,
            vecs[i].is_exception, vecs[i].exc_address);
      step_check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                 vecs[i].exp_mis, vecs[i].exp_pend);
    end

    // A branch held high is a fresh request every cycle, stalled or not.
    drive(1, 1, 1, 32'h80000b00, 0, 32'h0);
    step_check("held_br0", 32'h80000b00, 1, 0, 0);
    step_check("held_br1", 32'h80000b00, 1, 0, 0);
    drive(1, 0, 1, 32'h80000c00, 0, 32'h0);
    step_check("held_stall0", 32'h80000b00, 1, 0, 1);
    step_check("held_stall1", 32'h80000b00, 1, 0, 1);
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    step_check("held_release", 32'h80000c00, 1, 0, 0);
    step_check("held_after", 32'h80000c04, 1, 0, 0);

    // Narrow instance: reset vector truncates to 0, step 2, bit 0 is the alignment bit.
    step16("n16_rst0", 0, 1, 0, 16'h0,    16'h0000, 0, 0);
    step16("n16_rst1", 0, 1, 0, 16'h0,    16'h0000, 0, 0);
    step16("n16_boot", 1, 1, 0, 16'h0,    16'h0000, 1, 0);
    step16("n16_inc",  1, 1, 0, 16'h0,    16'h0002, 1, 0);
    step16("n16_br",   1, 1, 1, 16'hfffe, 16'hfffe, 1, 0);
    step16("n16_wrap", 1, 1, 0, 16'h0,    16'h0000, 1, 0);
    step16("n16_mis",  1, 1, 1, 16'h0001, 16'h0001, 1, 1);
    step16("n16_mis2", 1, 1, 0, 16'h0,    16'h0003, 1, 1);
    check("n16 pend", 32'(redirect_pending2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
